// File: rtl/exu_flush_ctrl_mt.sv
// Per-slot flush/stall controller for the barrel-scheduled EXU.
// Each thread slot owns a stall counter that is consumed only on that slot's own turns.
module exu_flush_ctrl_mt #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned BR_DEPTH   = 1,
  parameter int unsigned TRAP_DEPTH = 2,
  parameter int unsigned GLB_DEPTH  = 1
) (
  input  logic                 hclk,
  input  logic                 hrstn,
  input  logic [CNT_W-1:0]     cycle_cnt,
  input  logic [1:0]           flush,
  output logic                 flush_stall,
  output logic [NUM_SLOTS-1:0] flush_stall_vec,
  output logic                 flush_busy,
  output logic                 flush_err
);

  localparam int unsigned MAX_BT = (BR_DEPTH > TRAP_DEPTH) ? BR_DEPTH : TRAP_DEPTH;
  localparam int unsigned MAX_D  = (MAX_BT > GLB_DEPTH) ? MAX_BT : GLB_DEPTH;
  localparam int unsigned SC_W   = $clog2(MAX_D + 1);

  localparam logic [1:0] FL_NONE = 2'd0;
  localparam logic [1:0] FL_BR   = 2'd1;
  localparam logic [1:0] FL_TRAP = 2'd2;
  localparam logic [1:0] FL_GLB  = 2'd3;

  logic [SC_W-1:0] cnt_q [NUM_SLOTS];
  logic [SC_W-1:0] cnt_d [NUM_SLOTS];
  logic            err_q;
  logic            err_d;
  logic            valid_c;
  logic [SC_W-1:0] depth_c;
  logic [SC_W-1:0] dec_c;

  function automatic logic [SC_W-1:0] max_f(input logic [SC_W-1:0] a, input logic [SC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign valid_c = (cycle_cnt != '0) && (cycle_cnt <= CNT_W'(NUM_SLOTS));

  always_comb begin
    depth_c = '0;
    case (flush)
      FL_BR:   depth_c = SC_W'(BR_DEPTH);
      FL_TRAP: depth_c = SC_W'(TRAP_DEPTH);
      FL_GLB:  depth_c = SC_W'(GLB_DEPTH);
      default: depth_c = '0;
    endcase
  end

  // Status outputs reflect counter state and the slot owning this cycle.
  always_comb begin
    flush_stall     = 1'b0;
    flush_stall_vec = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      flush_stall_vec[i] = (cnt_q[i] != '0);
      if (valid_c && (cycle_cnt == CNT_W'(i + 1)) && (cnt_q[i] != '0)) begin
        flush_stall = 1'b1;
      end
    end
    flush_busy = |flush_stall_vec;
  end

  // Owning slot consumes one turn and takes the deeper of remaining/new stall;
  // a global flush raises every other slot without consuming their turns.
  always_comb begin
    err_d = 1'b0;
    dec_c = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (valid_c) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (cycle_cnt == CNT_W'(i + 1)) begin
          dec_c    = (cnt_q[i] != '0) ? (cnt_q[i] - SC_W'(1)) : '0;
          cnt_d[i] = (flush == FL_NONE) ? dec_c : max_f(dec_c, depth_c);
        end else if (flush == FL_GLB) begin
          cnt_d[i] = max_f(cnt_q[i], SC_W'(GLB_DEPTH));
        end
      end
    end else begin
      err_d = (flush != FL_NONE);
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  assign flush_err = err_q;

endmodule

// File: tb/tb_exu_flush_ctrl_mt.sv
// Directed bench for exu_flush_ctrl_mt with NUM_SLOTS=4, BR=1, TRAP=2, GLB=1.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_exu_flush_ctrl_mt;

  logic       hclk;
  logic       hrstn;
  logic [3:0] cycle_cnt;
  logic [1:0] flush;
  logic       flush_stall;
  logic [3:0] flush_stall_vec;
  logic       flush_busy;
  logic       flush_err;

  int checks;
  int errors;

  exu_flush_ctrl_mt #(
    .NUM_SLOTS (4),
    .CNT_W     (4),
    .BR_DEPTH  (1),
    .TRAP_DEPTH(2),
    .GLB_DEPTH (1)
  ) dut (
    .hclk           (hclk),
    .hrstn          (hrstn),
    .cycle_cnt      (cycle_cnt),
    .flush          (flush),
    .flush_stall    (flush_stall),
    .flush_stall_vec(flush_stall_vec),
    .flush_busy     (flush_busy),
    .flush_err      (flush_err)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One scheduler cycle: apply slot/flush, then check this cycle's outputs.
  task automatic turn(input string tag, input logic [3:0] cc, input logic [1:0] fl,
                      input logic st, input logic [3:0] vec, input logic err);
    @(negedge hclk);
    cycle_cnt = cc;
    flush     = fl;
    #1;
    chk({tag, ".stall"}, 32'(flush_stall), 32'(st));
    chk({tag, ".vec"},   32'(flush_stall_vec), 32'(vec));
    chk({tag, ".busy"},  32'(flush_busy), 32'(vec != 4'b0));
    chk({tag, ".err"},   32'(flush_err), 32'(err));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    hrstn     = 1'b0;
    cycle_cnt = 4'd1;
    flush     = 2'd1;

    // Reset held with a flush pending
    #3;
    chk("rst.vec", 32'(flush_stall_vec), 32'h0);
    chk("rst.stall", 32'(flush_stall), 32'h0);
    #14;
    chk("rst.busy", 32'(flush_busy), 32'h0);
    chk("rst.err", 32'(flush_err), 32'h0);
    #3;
    @(negedge hclk);
    flush = 2'd0;
    hrstn = 1'b1;
    turn("idle1", 4'd1, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("idle2", 4'd2, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("idle3", 4'd3, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("idle4", 4'd4, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Branch flush at slot 2
    turn("br.req", 4'd2, 2'd1, 1'b0, 4'b0000, 1'b0);
    turn("br.s3",  4'd3, 2'd0, 1'b0, 4'b0010, 1'b0);
    turn("br.s4",  4'd4, 2'd0, 1'b0, 4'b0010, 1'b0);
    turn("br.s1",  4'd1, 2'd0, 1'b0, 4'b0010, 1'b0);
    turn("br.s2",  4'd2, 2'd0, 1'b1, 4'b0010, 1'b0);
    turn("br.end", 4'd3, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("br.e4",  4'd4, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("br.e1",  4'd1, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Trap flush at slot 3: two stalled turns
    turn("tr.s2",  4'd2, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("tr.req", 4'd3, 2'd2, 1'b0, 4'b0000, 1'b0);
    turn("tr.a4",  4'd4, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("tr.a1",  4'd1, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("tr.a2",  4'd2, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("tr.t1",  4'd3, 2'd0, 1'b1, 4'b0100, 1'b0);
    turn("tr.b4",  4'd4, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("tr.b1",  4'd1, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("tr.b2",  4'd2, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("tr.t2",  4'd3, 2'd0, 1'b1, 4'b0100, 1'b0);
    turn("tr.c4",  4'd4, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("tr.c1",  4'd1, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("tr.c2",  4'd2, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("tr.t3",  4'd3, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Global flush at slot 1
    turn("gl.s4",  4'd4, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("gl.req", 4'd1, 2'd3, 1'b0, 4'b0000, 1'b0);
    turn("gl.s2",  4'd2, 2'd0, 1'b1, 4'b1111, 1'b0);
    turn("gl.s3",  4'd3, 2'd0, 1'b1, 4'b1101, 1'b0);
    turn("gl.s4b", 4'd4, 2'd0, 1'b1, 4'b1001, 1'b0);
    turn("gl.s1",  4'd1, 2'd0, 1'b1, 4'b0001, 1'b0);
    turn("gl.end", 4'd2, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Re-flush during a stalled turn does not stack
    turn("rf.req", 4'd3, 2'd2, 1'b0, 4'b0000, 1'b0);
    turn("rf.a4",  4'd4, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("rf.a1",  4'd1, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("rf.a2",  4'd2, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("rf.t1",  4'd3, 2'd1, 1'b1, 4'b0100, 1'b0);
    turn("rf.b4",  4'd4, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("rf.b1",  4'd1, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("rf.b2",  4'd2, 2'd0, 1'b0, 4'b0100, 1'b0);
    turn("rf.t2",  4'd3, 2'd0, 1'b1, 4'b0100, 1'b0);
    turn("rf.c4",  4'd4, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("rf.c1",  4'd1, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("rf.c2",  4'd2, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("rf.t3",  4'd3, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Invalid cycle_cnt: error pulse, counters untouched
    turn("iv.req0", 4'd0, 2'd2, 1'b0, 4'b0000, 1'b0);
    turn("iv.pul",  4'd1, 2'd0, 1'b0, 4'b0000, 1'b1);
    turn("iv.clr",  4'd2, 2'd0, 1'b0, 4'b0000, 1'b0);
    turn("iv.ld2",  4'd2, 2'd1, 1'b0, 4'b0000, 1'b0);
    turn("iv.req5", 4'd5, 2'd3, 1'b0, 4'b0010, 1'b0);
    turn("iv.q5",   4'd5, 2'd0, 1'b0, 4'b0010, 1'b1);
    turn("iv.s2",   4'd2, 2'd0, 1'b1, 4'b0010, 1'b0);
    turn("iv.done", 4'd3, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Async reset mid-stall with an error pulse pending
    turn("ar.req",  4'd3, 2'd2, 1'b0, 4'b0000, 1'b0);
    turn("ar.inv",  4'd0, 2'd1, 1'b0, 4'b0100, 1'b0);
    turn("ar.s3",   4'd3, 2'd0, 1'b1, 4'b0100, 1'b1);
    #2;
    hrstn = 1'b0;
    #1;
    chk("ar.vec",   32'(flush_stall_vec), 32'h0);
    chk("ar.stall", 32'(flush_stall), 32'h0);
    chk("ar.busy",  32'(flush_busy), 32'h0);
    chk("ar.err",   32'(flush_err), 32'h0);
    @(negedge hclk);
    hrstn = 1'b1;
    turn("ar.post", 4'd3, 2'd0, 1'b0, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
